// File: rtl/jk_pkg.sv
// JK command encoding shared by the steering logic and the storage cells.
package jk_pkg;

   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_RST  = 2'b01,
      JK_SET  = 2'b10,
      JK_TOG  = 2'b11
   } jk_cmd_t;

   // Minimal command to move one bit from cur to tgt.
   function automatic jk_cmd_t jk_for_target(input logic cur, input logic tgt);
      if (cur == tgt) return JK_HOLD;
      return tgt ? JK_SET : JK_RST;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One rising-edge JK storage bit with asynchronous active-low clear.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q,
   output logic q_bar
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         unique case (jk_cmd_t'({j, k}))
            JK_HOLD: q <= q;
            JK_RST:  q <= 1'b0;
            JK_SET:  q <= 1'b1;
            JK_TOG:  q <= ~q;
         endcase
      end
   end

   assign q_bar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter: J/K steering over a column of jk_cell bits,
// with parallel load, combinational terminal count and registered wrap pulse.
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] tgt;
   logic             at_max;
   logic             at_zero;
   logic             illegal;
   jk_cmd_t          cmd [WIDTH];

   assign at_zero = &count_n;
   assign at_max  = (count == MAX);
   assign illegal = (int'(count) >= MOD);
   assign tgt     = (int'(load_val) >= MOD) ? MAX : load_val;
   assign tc      = en & ~load & (up_dn ? at_max : at_zero);

   // Ripple term: toggle bit i when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      logic ripple;
      ripple = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) cmd[i] = JK_HOLD;
      if (load) begin
         for (int unsigned i = 0; i < WIDTH; i++) cmd[i] = tgt[i] ? JK_SET : JK_RST;
      end else if (en) begin
         if (up_dn) begin
            if (at_max || illegal) begin
               for (int unsigned i = 0; i < WIDTH; i++) cmd[i] = JK_RST;
            end else begin
               for (int unsigned i = 0; i < WIDTH; i++) begin
                  if (ripple) cmd[i] = JK_TOG;
                  ripple = ripple & count[i];
               end
            end
         end else begin
            if (at_zero || illegal) begin
               for (int unsigned i = 0; i < WIDTH; i++) cmd[i] = MAX[i] ? JK_SET : JK_RST;
            end else begin
               for (int unsigned i = 0; i < WIDTH; i++) begin
                  if (ripple) cmd[i] = JK_TOG;
                  ripple = ripple & count_n[i];
               end
            end
         end
      end
   end

   always_comb begin
      j = '0;
      k = '0;
      for (int unsigned i = 0; i < WIDTH; i++) {j[i], k[i]} = cmd[i];
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .j     (j[g]),
         .k     (k[g]),
         .q     (count[g]),
         .q_bar (count_n[g])
      );
   end

   // A wrapping edge is exactly an edge taken while tc is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wrap <= 1'b0;
      else        wrap <= tc;
   end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed self-checking bench for jk_mod_counter (WIDTH=4, MOD=10).
module tb_jk_mod_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       tc;
   logic       wrap;

   int n_checks = 0;
   int n_fail   = 0;

   jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int exp_up   [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
   int exp_down [3]  = '{0, 9, 8};
   int prev;

   initial begin
      rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
      #2;
      check("rst_count", 32'(count), 0);
      check("rst_wrap", 32'(wrap), 0);
      #10 rst_n = 1'b1;

      // Test 1: asynchronous reset mid-cycle from count=7
      load = 1'b1; load_val = 4'd7;
      tick();
      load = 1'b0;
      check("load7", 32'(count), 7);
      #3;
      en = 1'b1; rst_n = 1'b0;
      #1;
      check("async_rst_count", 32'(count), 0);
      check("async_rst_wrap", 32'(wrap), 0);
      tick();
      check("rst_hold_count", 32'(count), 0);
      check("rst_hold_wrap", 32'(wrap), 0);
      rst_n = 1'b1; en = 1'b0;
      tick();
      check("rst_release", 32'(count), 0);

      // Test 2: count up 12 edges
      en = 1'b1; up_dn = 1'b1;
      prev = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         check("up_tc", 32'(tc), (prev == 9) ? 1 : 0);
         tick();
         check("up_count", 32'(count), 32'(exp_up[i]));
         check("up_wrap", 32'(wrap), (prev == 9) ? 1 : 0);
         prev = exp_up[i];
      end

      // Test 3: count down from 1
      up_dn = 1'b0;
      tick();
      check("dn_to1", 32'(count), 1);
      prev = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("dn_tc", 32'(tc), (prev == 0) ? 1 : 0);
         tick();
         check("dn_count", 32'(count), 32'(exp_down[i]));
         check("dn_wrap", 32'(wrap), (prev == 0) ? 1 : 0);
         prev = exp_down[i];
      end

      // Test 4: load overrides enable
      load = 1'b1; load_val = 4'd5; en = 1'b1; up_dn = 1'b1;
      #1;
      check("load_tc", 32'(tc), 0);
      tick();
      check("load5", 32'(count), 5);
      check("load_wrap", 32'(wrap), 0);
      load = 1'b0;
      tick();
      check("after_load", 32'(count), 6);

      // Test 5: clamped load then wrap
      load = 1'b1; load_val = 4'hE;
      tick();
      check("clamp", 32'(count), 9);
      load = 1'b0;
      #1;
      check("clamp_tc", 32'(tc), 1);
      tick();
      check("clamp_wrap_count", 32'(count), 0);
      check("clamp_wrap", 32'(wrap), 1);

      // Test 6: enable gaps with direction changes
      load = 1'b1; load_val = 4'd3;
      tick();
      check("load3", 32'(count), 3);
      load = 1'b0; en = 1'b1; up_dn = 1'b1;
      tick();
      check("mix_up", 32'(count), 4);
      check("mix_up_wrap", 32'(wrap), 0);
      en = 1'b0; up_dn = 1'b0;
      #1;
      check("mix_hold_tc", 32'(tc), 0);
      check("mix_hold_jk", 32'({dut.j, dut.k}), 0);
      tick();
      check("mix_hold", 32'(count), 4);
      check("mix_hold_wrap", 32'(wrap), 0);
      en = 1'b1; up_dn = 1'b0;
      tick();
      check("mix_dn", 32'(count), 3);
      check("mix_dn_wrap", 32'(wrap), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
